rvlab_shift_sched: RTL and testbench

//  Round-robin scheduler sharing one iterative logical shifter among NREQ requesters.

---
 rtl/rvlab_shift_sched.sv | 181 ++++++++++++++++++
 tb/tb_rvlab_shift_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvlab_shift_sched.sv
// Round-robin scheduler sharing one iterative shifter (up to STEP bits/cycle) among NREQ requesters.
// Optional rotate support is enabled by defining RVLAB_SHIFT_SCHED_ROTATE_EN.
module rvlab_shift_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned STEP = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NREQ-1:0]             req_valid_i,
    output logic [NREQ-1:0]             req_ready_o,
    input  logic [NREQ*W-1:0]           req_data_i,
    input  logic [NREQ*$clog2(W)-1:0]   req_amt_i,
    input  logic [NREQ-1:0]             req_dir_i,
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
    input  logic [NREQ-1:0]             req_rot_i,
`endif
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [W-1:0]                rsp_data_o,
    output logic [$clog2(NREQ)-1:0]     rsp_id_o,
    output logic                        busy_o
);

    localparam int unsigned AW = $clog2(W);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned SW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_id;
    logic [W-1:0]    r_acc;
    logic [AW-1:0]   r_rem;
    logic            r_dir;
    logic            r_rsp_valid;
    logic            r_busy;

    logic            w_found;
    logic            w_accept;
    logic [IW-1:0]   w_scan;
    logic [IW-1:0]   w_gnt_id;
    logic [W-1:0]    w_sel_data;
    logic [AW-1:0]   w_sel_amt;
    logic            w_sel_dir;
    logic [SW-1:0]   w_step;
    logic [W-1:0]    w_acc_nxt;

`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
    logic            r_rot;
    logic            w_sel_rot;
    logic [W-1:0]    w_rot_r;
    logic [W-1:0]    w_rot_l;
`endif

    // Round-robin scan starting one past the last winner, with wrap.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_scan   = r_rr;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_scan = (w_scan == IW'(NREQ - 1)) ? '0 : w_scan + IW'(1);
            if (!w_found && req_valid_i[w_scan]) begin
                w_found  = 1'b1;
                w_gnt_id = w_scan;
            end
        end
    end

    assign w_accept    = (r_state == S_IDLE) && w_found;
    assign req_ready_o = w_accept ? (NREQ'(1) << w_gnt_id) : '0;

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_data = '0;
        w_sel_amt  = '0;
        w_sel_dir  = 1'b0;
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
        w_sel_rot  = 1'b0;
`endif
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt_id == IW'(i)) begin
                w_sel_data = req_data_i[i*W +: W];
                w_sel_amt  = req_amt_i[i*AW +: AW];
                w_sel_dir  = req_dir_i[i];
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
                w_sel_rot  = req_rot_i[i];
`endif
            end
        end
    end

    assign w_step = (SW'(r_rem) < SW'(STEP)) ? SW'(r_rem) : SW'(STEP);

`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
    assign w_rot_r = W'({r_acc, r_acc} >> w_step);
    assign w_rot_l = W'(({r_acc, r_acc} << w_step) >> W);
`endif

    always_comb begin
        w_acc_nxt = r_dir ? (r_acc >> w_step) : (r_acc << w_step);
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
        if (r_rot) begin
            w_acc_nxt = r_dir ? w_rot_r : w_rot_l;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_sel_amt == '0) ? S_RESP : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_rem == AW'(w_step)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job capture, iterative shift and registered response flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr        <= IW'(NREQ - 1);
            r_id        <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_dir       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
            r_rot       <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_acc <= w_sel_data;
                r_rem <= w_sel_amt;
                r_dir <= w_sel_dir;
                r_id  <= w_gnt_id;
                r_rr  <= w_gnt_id;
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
                r_rot <= w_sel_rot;
`endif
            end else if (r_state == S_SHIFT) begin
                r_acc <= w_acc_nxt;
                r_rem <= r_rem - AW'(w_step);
            end
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_acc;
    assign rsp_id_o    = r_id;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_rvlab_shift_sched.sv
// Self-checking bench for rvlab_shift_sched: vector table, corner sequences and a
// randomized run against an arithmetic reference model. Rotate cases need RVLAB_SHIFT_SCHED_ROTATE_EN.
module tb_rvlab_shift_sched;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int STEP = 4;
    localparam int AW   = 5;
    localparam int IW   = 2;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_data;
    logic [NREQ*AW-1:0]   req_amt;
    logic [NREQ-1:0]      req_dir;
    logic [NREQ-1:0]      req_rot;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [W-1:0]         rsp_data;
    logic [IW-1:0]        rsp_id;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr;

    rvlab_shift_sched #(.NREQ(NREQ), .W(W), .STEP(STEP)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .req_amt_i   (req_amt),
        .req_dir_i   (req_dir),
`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
        .req_rot_i   (req_rot),
`endif
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .busy_o      (busy)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         id;
        logic [W-1:0] data;
        int         amt;
        bit         dir;
        logic [W-1:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int amt,
                                               input bit dir, input bit rot);
        if (amt == 0) return d;
        if (!rot) return dir ? (d >> amt) : (d << amt);
        return dir ? ((d >> amt) | (d << (W - amt))) : ((d << amt) | (d >> (W - amt)));
    endfunction

    function automatic int ref_lat(input int amt);
        return 1 + (amt + STEP - 1) / STEP;
    endfunction

    function automatic int ref_winner(input logic [NREQ-1:0] v, input int rr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int id, input logic [W-1:0] d, input int amt,
                           input bit dir, input bit rot);
        req_valid[id]          = 1'b1;
        req_data[id*W +: W]    = d;
        req_amt[id*AW +: AW]   = AW'(amt);
        req_dir[id]            = dir;
        req_rot[id]            = rot;
    endtask

    task automatic do_reset();
        rst_ni    = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_ni   = 1'b1;
        model_rr = NREQ - 1;
    endtask

    // Wait (bounded) for rsp_valid after the accept edge; returns cycles counted.
    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk_i);
            cyc++;
        end
    endtask

    task automatic run_single(input int id, input logic [W-1:0] d, input int amt, input bit dir,
                              input bit rot, input logic [W-1:0] exp_d, input int exp_l,
                              input string tag);
        int cyc;
        set_req(id, d, amt, dir, rot);
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'(1 << id));
        @(negedge clk_i);
        req_valid[id] = 1'b0;
        model_rr = id;
        wait_rsp(cyc);
        check({tag, "_lat"}, 64'(cyc), 64'(exp_l));
        check({tag, "_data"}, 64'(rsp_data), 64'(exp_d));
        check({tag, "_id"}, 64'(rsp_id), 64'(id));
        rsp_ready = 1'b1;
        @(negedge clk_i);
        rsp_ready = 1'b0;
        check({tag, "_done"}, 64'({rsp_valid, busy}), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int cyc;
        int t;
        int win;
        logic [W-1:0] exp_d;
        int exp_l;
        bit seen;
        logic [W-1:0] p_data [NREQ];
        int           p_amt  [NREQ];
        bit           p_dir  [NREQ];

        vecs[0] = '{0, 32'h0000_00F0,  4, 1'b1, 32'h0000_000F, 2};
        vecs[1] = '{1, 32'h8000_0001,  0, 1'b0, 32'h8000_0001, 1};
        vecs[2] = '{2, 32'h0000_0001, 31, 1'b0, 32'h8000_0000, 9};
        vecs[3] = '{3, 32'hFFFF_FFFF, 31, 1'b1, 32'h0000_0001, 9};
        vecs[4] = '{0, 32'h1234_5678,  8, 1'b0, 32'h3456_7800, 3};
        vecs[5] = '{1, 32'h1234_5678,  5, 1'b1, 32'h0091_A2B3, 3};
        vecs[6] = '{2, 32'hA5A5_A5A5,  1, 1'b0, 32'h4B4B_4B4A, 2};

        req_data  = '0;
        req_amt   = '0;
        req_dir   = '0;
        req_rot   = '0;
        @(negedge clk_i);
        do_reset();

        foreach (vecs[i]) begin
            run_single(vecs[i].id, vecs[i].data, vecs[i].amt, vecs[i].dir, 1'b0,
                       vecs[i].exp_data, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

`ifdef RVLAB_SHIFT_SCHED_ROTATE_EN
        run_single(0, 32'h0000_0001, 1, 1'b1, 1'b1, 32'h8000_0000, 2, "rot_on");
        run_single(0, 32'h0000_0001, 1, 1'b1, 1'b0, 32'h0000_0000, 2, "rot_off");
        run_single(1, 32'h8000_0001, 7, 1'b0, 1'b1, 32'h0000_00C0, 3, "rot_left");
`endif

        // All four requesting continuously: grants rotate 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'h1, 31, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            t = 0;
            while (req_ready == '0 && t < 20) begin
                @(negedge clk_i);
                t++;
            end
            check($sformatf("rr_grant%0d", g), 64'(req_ready), 64'(1 << (g % NREQ)));
            @(negedge clk_i);
            if (g == 4) req_valid = '0;
            wait_rsp(cyc);
            check($sformatf("rr_lat%0d", g), 64'(cyc), 64'd9);
            check($sformatf("rr_data%0d", g), 64'(rsp_data), 64'h8000_0000);
            check($sformatf("rr_id%0d", g), 64'(rsp_id), 64'(g % NREQ));
            @(negedge clk_i);
        end
        rsp_ready = 1'b0;

        // Response stall with other requesters waiting.
        do_reset();
        set_req(3, 32'hF000_000F, 3, 1'b1, 1'b0);
        @(negedge clk_i);
        req_valid = 4'b0111;
        wait_rsp(cyc);
        check("stall_lat", 64'(cyc), 64'd2);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk_i);
            check($sformatf("stall_data%0d", s), 64'(rsp_data), 64'h1E00_0001);
            check($sformatf("stall_id%0d", s), 64'(rsp_id), 64'd3);
            check($sformatf("stall_flags%0d", s), 64'({rsp_valid, busy, req_ready}), 64'h30);
        end

        // Reset in the middle of a 20-bit shift drops the job.
        do_reset();
        set_req(2, 32'hDEAD_BEEF, 20, 1'b1, 1'b0);
        @(negedge clk_i);
        req_valid = '0;
        @(negedge clk_i);
        check("midrst_busy", 64'(busy), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("midrst_outs", 64'({req_ready, rsp_valid, rsp_data, rsp_id, busy}), 64'd0);
        @(negedge clk_i);
        rst_ni    = 1'b1;
        model_rr  = NREQ - 1;
        rsp_ready = 1'b1;
        seen      = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            seen = seen | rsp_valid | busy;
        end
        check("midrst_no_rsp", 64'(seen), 64'd0);
        rsp_ready = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        for (int j = 0; j < 60; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    p_data[i] = $urandom;
                    p_amt[i]  = $urandom_range(0, W - 1);
                    p_dir[i]  = 1'($urandom_range(0, 1));
                    set_req(i, p_data[i], p_amt[i], p_dir[i], 1'b0);
                end
            end
            #1;
            if (req_valid == '0) begin
                check("rnd_noreq", 64'(req_ready), 64'd0);
                @(negedge clk_i);
                continue;
            end
            win = ref_winner(req_valid, model_rr);
            check($sformatf("rnd%0d_grant", j), 64'(req_ready), 64'(1 << win));
            exp_d = ref_shift(p_data[win], p_amt[win], p_dir[win], 1'b0);
            exp_l = ref_lat(p_amt[win]);
            @(negedge clk_i);
            model_rr       = win;
            req_valid[win] = 1'b0;
            cyc = 1;
            while (!rsp_valid && cyc < 40) begin
                check($sformatf("rnd%0d_noready", j), 64'(req_ready), 64'd0);
                @(negedge clk_i);
                cyc++;
            end
            check($sformatf("rnd%0d_lat", j), 64'(cyc), 64'(exp_l));
            check($sformatf("rnd%0d_data", j), 64'(rsp_data), 64'(exp_d));
            check($sformatf("rnd%0d_id", j), 64'(rsp_id), 64'(win));
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk_i);
                check($sformatf("rnd%0d_hold", j), 64'({req_ready, rsp_valid, rsp_data}),
                      64'({4'b0000, 1'b1, exp_d}));
            end
            rsp_ready = 1'b1;
            @(negedge clk_i);
            rsp_ready = 1'b0;
            check($sformatf("rnd%0d_idle", j), 64'({rsp_valid, busy}), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
